// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared opcode map, opcode-to-ALU-string conversion and FSM state encoding
// for the ALU command sequencer.
package alu_pkg;

  localparam logic [2:0] OP_AND        = 3'd0;
  localparam logic [2:0] OP_SUBTRACT   = 3'd1;
  localparam logic [2:0] OP_SUBTRACT_A = 3'd2;
  localparam logic [2:0] OP_OR_AB      = 3'd3;
  localparam logic [2:0] OP_AND_AB     = 3'd4;
  localparam logic [2:0] OP_NOT_AB     = 3'd5;
  localparam logic [2:0] OP_EXOR       = 3'd6;
  localparam logic [2:0] OP_EXNOR      = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // String literals zero-extend on the left, giving the right-justified form.
  function automatic logic [119:0] op2str(input logic [2:0] op);
    logic [119:0] s;
    case (op)
      OP_AND:        s = "and";
      OP_SUBTRACT:   s = "subtract";
      OP_SUBTRACT_A: s = "subtract_a";
      OP_OR_AB:      s = "or_ab";
      OP_AND_AB:     s = "and_ab";
      OP_NOT_AB:     s = "not_ab";
      OP_EXOR:       s = "exor";
      OP_EXNOR:      s = "exnor";
      default:       s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Generic synchronous FIFO; one slot is kept free so full/empty come from
// pointer compares alone (capacity DEPTH-1).
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = ((wr_ptr + 1'b1) == rd_ptr);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Feeds buffered commands to a combinational ALU and returns {c_out,sum}
// over a valid/ready handshake. Optional accumulator: define ALU_ACC_EN.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [2:0]     cmd_op,
  input  logic [W-1:0]   cmd_a,
  input  logic [W-1:0]   cmd_b,
  input  logic           cmd_cin,
  input  logic           cmd_use_acc,
  output logic [119:0]   alu_oper,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic           alu_cin,
  input  logic           alu_c_out,
  input  logic [W-1:0]   alu_sum,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [W:0]     res_data
);

  localparam int CW = 3 + 2*W + 2;

  state_t          state;
  logic [CW-1:0]   head;
  logic            empty;
  logic            full;
  logic            push;
  logic            pop;
  logic [2:0]      head_op;
  logic [W-1:0]    head_a;
  logic [W-1:0]    head_b;
  logic            head_cin;
  logic            head_use;
  logic [W-1:0]    next_a;

  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = !empty && ((state == IDLE) || ((state == HOLD) && res_ready));

  assign head_op  = head[2*W+2 +: 3];
  assign head_a   = head[W+2 +: W];
  assign head_b   = head[2 +: W];
  assign head_cin = head[1];
  assign head_use = head[0];

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata ({cmd_op, cmd_a, cmd_b, cmd_cin, cmd_use_acc}),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

`ifdef ALU_ACC_EN
  logic [W-1:0] acc;
  assign next_a = head_use ? acc : head_a;
`else
  logic unused_use_acc;
  assign unused_use_acc = head_use;
  assign next_a = head_a;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      alu_oper  <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_cin   <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
`ifdef ALU_ACC_EN
      acc       <= '0;
`endif
    end else begin
      // ALU operands change only on a pop, so they stay put in IDLE/HOLD.
      if (pop) begin
        alu_oper <= op2str(head_op);
        alu_a    <= next_a;
        alu_b    <= head_b;
        alu_cin  <= head_cin;
      end
      case (state)
        IDLE: begin
          if (!empty) state <= ISSUE;
        end
        ISSUE: begin
          res_data  <= {alu_c_out, alu_sum};
          res_valid <= 1'b1;
`ifdef ALU_ACC_EN
          acc       <= alu_sum;
`endif
          state     <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= empty ? IDLE : ISSUE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
